// File: rtl/motor_drv_if.sv
// Command and drive bundle between dig_core and the H-bridge PWM stage.
// master drives the commands; slave (motor_drv) drives the bridge legs and period marker.
interface motor_drv_if;
    logic               go;
    logic signed [10:0] lft;
    logic signed [10:0] rht;
    logic               fwd_lft;
    logic               rev_lft;
    logic               fwd_rht;
    logic               rev_rht;
    logic               pwm_sync;

    modport master (
        output go, lft, rht,
        input  fwd_lft, rev_lft, fwd_rht, rev_rht, pwm_sync
    );

    modport slave (
        input  go, lft, rht,
        output fwd_lft, rev_lft, fwd_rht, rev_rht, pwm_sync
    );
endinterface

// File: rtl/motor_drv.sv
// Dual H-bridge PWM driver: period-aligned command shadowing, immediate brake on go low,
// dead-time on reversal. Outputs registered (1 clk after compare); no backpressure.
module motor_drv #(
    parameter int PWM_W    = 10,
    parameter int DEADTIME = 32
) (
    input  logic       clk,
    input  logic       rst,
    motor_drv_if.slave bus
);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DEAD  = 2'd1;
    localparam logic [1:0] ST_BRAKE = 2'd2;

    localparam int              CW      = (PWM_W > 11) ? PWM_W : 11;
    localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};
    localparam logic [CW-1:0]   DT      = CW'(DEADTIME);

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    cnt_w;
    logic             boundary;
    logic             sync_q;

    logic signed [10:0] cmd    [2];
    logic [10:0]        duty_q [2];
    logic [10:0]        duty_d [2];
    logic               dir_q  [2];
    logic               dir_d  [2];
    logic [1:0]         st_q   [2];
    logic [1:0]         st_d   [2];
    logic               fwd_q  [2];
    logic               fwd_d  [2];
    logic               rev_q  [2];
    logic               rev_d  [2];
    logic               nd     [2];
    logic               act    [2];

    // Magnitude at 11 bits; -1024 is the only value whose negation overflows.
    function automatic logic [10:0] sat_mag(input logic signed [10:0] c);
        logic [10:0] m;
        m = c[10] ? 11'(-c) : 11'(c);
        if (m[10]) begin
            m = 11'd1023;
        end
        return m;
    endfunction

    assign cmd[0]   = bus.lft;
    assign cmd[1]   = bus.rht;
    assign boundary = (cnt_q == CNT_MAX);
    assign cnt_d    = cnt_q + PWM_W'(1);
    assign cnt_w    = CW'(cnt_q);

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nd[s]     = (cmd[s] == 11'sd0) ? dir_q[s] : cmd[s][10];
            act[s]    = (cnt_w < CW'(duty_q[s]));
            st_d[s]   = st_q[s];
            dir_d[s]  = dir_q[s];
            duty_d[s] = duty_q[s];
            fwd_d[s]  = 1'b0;
            rev_d[s]  = 1'b0;

            if (boundary) begin
                duty_d[s] = sat_mag(cmd[s]);
                dir_d[s]  = nd[s];
            end

            case (st_q[s])
                ST_RUN: begin
                    fwd_d[s] = !dir_q[s] && act[s];
                    rev_d[s] =  dir_q[s] && act[s];
                    if (boundary && (nd[s] != dir_q[s])) begin
                        st_d[s] = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    fwd_d[s] = !dir_q[s] && act[s] && (cnt_w >= DT);
                    rev_d[s] =  dir_q[s] && act[s] && (cnt_w >= DT);
                    if (boundary) begin
                        st_d[s] = (nd[s] != dir_q[s]) ? ST_DEAD : ST_RUN;
                    end
                end
                default: begin
                    fwd_d[s] = 1'b1;
                    rev_d[s] = 1'b1;
                    if (boundary) begin
                        st_d[s] = (nd[s] != dir_q[s]) ? ST_DEAD : ST_RUN;
                    end
                end
            endcase

            // go low brakes on this very edge and keeps the pre-brake direction.
            if (!bus.go) begin
                st_d[s]  = ST_BRAKE;
                dir_d[s] = dir_q[s];
                fwd_d[s] = 1'b1;
                rev_d[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sync_q <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                duty_q[s] <= '0;
                dir_q[s]  <= 1'b0;
                st_q[s]   <= ST_BRAKE;
                fwd_q[s]  <= 1'b0;
                rev_q[s]  <= 1'b0;
            end
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= boundary;
            for (int s = 0; s < 2; s++) begin
                duty_q[s] <= duty_d[s];
                dir_q[s]  <= dir_d[s];
                st_q[s]   <= st_d[s];
                fwd_q[s]  <= fwd_d[s];
                rev_q[s]  <= rev_d[s];
            end
        end
    end

    assign bus.fwd_lft  = fwd_q[0];
    assign bus.rev_lft  = rev_q[0];
    assign bus.fwd_rht  = fwd_q[1];
    assign bus.rev_rht  = rev_q[1];
    assign bus.pwm_sync = sync_q;
endmodule

// File: tb/tb_motor_drv.sv
// Bench for motor_drv: per-period pulse-width reference model, directed plus random commands.
module tb_motor_drv;
    localparam int P   = 1024;
    localparam int DT  = 32;
    localparam int BRK = 0;
    localparam int RUN = 1;
    localparam int DED = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    motor_drv_if bus ();

    motor_drv #(.PWM_W(10), .DEADTIME(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: cnt phase, per-side mode/dir/duty for the current period, and per-period tallies.
    int m;
    int mode [2];
    int dir  [2];
    int duty [2];
    int fcnt [2];
    int rcnt [2];
    int ffst [2];
    int rfst [2];
    int excl_bad [2];
    int brk_bad  [2];
    int sync_bad;
    bit dirty;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.fwd_lft, bus.rev_lft, bus.fwd_rht, bus.rev_rht, bus.pwm_sync});
    endfunction

    function automatic int mag(input int c);
        if (c < -1023) return 1023;
        return (c < 0) ? -c : c;
    endfunction

    function automatic int rnd_cmd();
        if ($urandom_range(0, 4) == 0) return 0;
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    task automatic clear_acc();
        for (int s = 0; s < 2; s++) begin
            fcnt[s] = 0; rcnt[s] = 0; ffst[s] = -1; rfst[s] = -1;
            excl_bad[s] = 0; brk_bad[s] = 0;
        end
        sync_bad = 0;
        dirty    = 1'b0;
    endtask

    task automatic model_reset();
        m = 0;
        for (int s = 0; s < 2; s++) begin
            mode[s] = BRK; dir[s] = 0; duty[s] = 0;
        end
        clear_acc();
    endtask

    task automatic finish_period();
        string nm;
        int ea, ef, ac, ia, af;
        for (int s = 0; s < 2; s++) begin
            nm = (s == 1) ? "rht" : "lft";
            chk({nm, "_excl"}, excl_bad[s], 0);
            chk({nm, "_brake_hold"}, brk_bad[s], 0);
            if (!dirty) begin
                if (mode[s] == BRK) begin
                    chk({nm, "_brake_fwd_cnt"}, fcnt[s], P);
                    chk({nm, "_brake_rev_cnt"}, rcnt[s], P);
                end else begin
                    ea = (mode[s] == DED) ? ((duty[s] > DT) ? duty[s] - DT : 0) : duty[s];
                    ef = (ea > 0) ? ((mode[s] == DED) ? DT : 0) : -1;
                    ac = (dir[s] != 0) ? rcnt[s] : fcnt[s];
                    ia = (dir[s] != 0) ? fcnt[s] : rcnt[s];
                    af = (dir[s] != 0) ? rfst[s] : ffst[s];
                    chk({nm, "_active_width"}, ac, ea);
                    chk({nm, "_inactive_width"}, ia, 0);
                    chk({nm, "_active_start"}, af, ef);
                end
            end
        end
        chk("pwm_sync", sync_bad, 0);
        clear_acc();
    endtask

    task automatic boundary_update(input bit go_e);
        int c, ndir;
        for (int s = 0; s < 2; s++) begin
            c = (s == 1) ? int'(bus.rht) : int'(bus.lft);
            duty[s] = mag(c);
            if (go_e) begin
                ndir    = (c == 0) ? dir[s] : ((c < 0) ? 1 : 0);
                mode[s] = (ndir != dir[s]) ? DED : RUN;
                dir[s]  = ndir;
            end else begin
                mode[s] = BRK;
            end
        end
    endtask

    // One clock: sample at the falling edge, score against the model, roll periods over.
    task automatic tick();
        int k, f, r;
        bit go_e;
        @(negedge clk);
        m    = (m + 1) % P;
        k    = (m + P - 1) % P;
        go_e = bus.go;
        if (!go_e) begin
            for (int s = 0; s < 2; s++) begin
                if (mode[s] != BRK) begin
                    mode[s] = BRK;
                    dirty   = 1'b1;
                end
            end
        end
        if (int'(bus.pwm_sync) != ((m == 0) ? 1 : 0)) sync_bad++;
        for (int s = 0; s < 2; s++) begin
            f = (s == 1) ? int'(bus.fwd_rht) : int'(bus.fwd_lft);
            r = (s == 1) ? int'(bus.rev_rht) : int'(bus.rev_lft);
            if (f != 0) begin fcnt[s]++; if (ffst[s] < 0) ffst[s] = k; end
            if (r != 0) begin rcnt[s]++; if (rfst[s] < 0) rfst[s] = k; end
            if (mode[s] != BRK && f != 0 && r != 0) excl_bad[s]++;
            if (mode[s] == BRK && !(f != 0 && r != 0)) brk_bad[s]++;
        end
        if (m == 0) begin
            finish_period();
            boundary_update(go_e);
        end
    endtask

    task automatic run_to(input int t);
        do tick(); while (m != t);
    endtask

    task automatic periods(input int n);
        repeat (n) run_to(0);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("rst_async_clear", outs(), 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_low", outs(), 0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int v;
        rst     = 1'b1;
        bus.go  = 1'b0;
        bus.lft = '0;
        bus.rht = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        model_reset();
        tick();
        chk("first_edge_brake", outs(), 30);

        // Forward 256 on both sides.
        bus.go = 1'b1; bus.lft = 11'sd256; bus.rht = 11'sd256;
        run_to(0);
        periods(3);

        // Saturation: -1024 / +1023.
        bus.lft = -11'sd1024; bus.rht = 11'sd1023;
        periods(3);

        // Reversal mid-period: +300 then -300 at cnt 512.
        bus.lft = 11'sd300; bus.rht = 11'sd100;
        periods(2);
        run_to(512);
        bus.lft = -11'sd300;
        periods(3);

        // Brake at cnt 100, go back at cnt 600.
        bus.lft = 11'sd500;
        periods(2);
        run_to(100);
        bus.go = 1'b0;
        tick();
        chk("go_drop_lft_brake", int'({bus.fwd_lft, bus.rev_lft}), 3);
        run_to(600);
        bus.go = 1'b1;
        periods(2);

        // Zero command keeps direction: no dead interval around it.
        bus.lft = -11'sd200;
        periods(3);
        bus.lft = 11'sd0;
        periods(2);
        bus.lft = -11'sd200;
        periods(2);

        // Reset mid-period while driving +800, release with go low.
        bus.lft = 11'sd800;
        periods(3);
        run_to(700);
        bus.go = 1'b0;
        reset_mid();
        tick();
        chk("post_reset_brake", int'({bus.fwd_lft, bus.rev_lft, bus.fwd_rht, bus.rev_rht}), 15);
        bus.go = 1'b1;
        periods(3);

        // Random commands changed at random points, with occasional brakes.
        repeat (16) begin
            run_to(int'($urandom_range(1, P - 1)));
            v = rnd_cmd(); bus.lft = v[10:0];
            v = rnd_cmd(); bus.rht = v[10:0];
            bus.go = ($urandom_range(0, 5) != 0);
            run_to(0);
        end
        bus.go = 1'b1;
        periods(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
